// File: rtl/hs_lane_sequencer.sv
// Multi-lane D-PHY HS transmit sequencer: drives the LP-11/01/00 entry, HS-zero,
// sync byte, LSB-first payload, trail and exit as two bits per lane per DDR clock.
module hs_lane_sequencer #(
    parameter int unsigned LANES        = 2,
    parameter int unsigned LPX_CYC      = 4,
    parameter int unsigned HS_PREP_CYC  = 4,
    parameter int unsigned HS_ZERO_CYC  = 12,
    parameter int unsigned HS_TRAIL_CYC = 6,
    parameter int unsigned HS_EXIT_CYC  = 8
) (
    input  logic                 TX_DDR_clk,
    input  logic                 TX_rst,
    input  logic                 TX_request_HS,
    input  logic [8*LANES-1:0]   TX_data,
    input  logic                 TX_valid,
    output logic                 TX_ready,
    output logic [LANES-1:0]     Serial_B1,
    output logic [LANES-1:0]     Serial_B2,
    output logic                 HS_Enable,
    output logic [LANES-1:0]     LP_Dp,
    output logic [LANES-1:0]     LP_Dn,
    output logic                 Stop_state,
    output logic                 Underrun
);

    localparam int unsigned MAX_AB   = (LPX_CYC > HS_PREP_CYC) ? LPX_CYC : HS_PREP_CYC;
    localparam int unsigned MAX_CD   = (HS_ZERO_CYC > HS_TRAIL_CYC) ? HS_ZERO_CYC : HS_TRAIL_CYC;
    localparam int unsigned MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned MAX_CYC  = (MAX_ABCD > HS_EXIT_CYC) ? MAX_ABCD : HS_EXIT_CYC;
    localparam int unsigned CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [7:0]  SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LP01,
        ST_LP00,
        ST_HS_ZERO,
        ST_SYNC,
        ST_DATA,
        ST_TRAIL,
        ST_EXIT
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              phase_q, phase_d;
    logic [LANES-1:0][7:0]   sr_q, sr_d;
    logic [LANES-1:0]        b1_q, b1_d, b2_q, b2_d;
    logic [LANES-1:0]        lpp_q, lpp_d, lpn_q, lpn_d;
    logic                    hs_q, hs_d;
    logic                    ready_q, ready_d;
    logic                    stop_q, stop_d;
    logic                    und_q, und_d;
    logic                    load;
    logic [LANES-1:0][7:0]   new_byte;

    // State, counters, shift registers and registered outputs
    always_ff @(posedge TX_DDR_clk) begin
        if (TX_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            sr_q    <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            lpp_q   <= '1;
            lpn_q   <= '1;
            hs_q    <= 1'b0;
            ready_q <= 1'b0;
            stop_q  <= 1'b1;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            sr_q    <= sr_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            lpp_q   <= lpp_d;
            lpn_q   <= lpn_d;
            hs_q    <= hs_d;
            ready_q <= ready_d;
            stop_q  <= stop_d;
            und_q   <= und_d;
        end
    end

    // Next state plus the outputs that the next state will present
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        sr_d     = sr_q;
        b1_d     = '0;
        b2_d     = '0;
        und_d    = 1'b0;
        load     = 1'b0;
        new_byte = TX_data;

        case (state_q)
            ST_IDLE: begin
                if (TX_request_HS) begin
                    state_d = ST_LP01;
                    cnt_d   = CNT_W'(LPX_CYC - 1);
                end
            end
            ST_LP01: begin
                if (!TX_request_HS) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_LP00;
                    cnt_d   = CNT_W'(HS_PREP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LP00: begin
                if (!TX_request_HS) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_HS_ZERO;
                    cnt_d   = CNT_W'(HS_ZERO_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HS_ZERO: begin
                if (cnt_q == '0) begin
                    state_d  = ST_SYNC;
                    phase_d  = 2'd0;
                    load     = 1'b1;
                    new_byte = {LANES{SYNC_BYTE}};
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SYNC, ST_DATA: begin
                if (phase_q == 2'd3) begin
                    if (TX_request_HS && TX_valid) begin
                        state_d = ST_DATA;
                        phase_d = 2'd0;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_TRAIL;
                        cnt_d   = CNT_W'(HS_TRAIL_CYC - 1);
                        und_d   = TX_request_HS;
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            ST_TRAIL: begin
                if (cnt_q == '0) begin
                    state_d = ST_EXIT;
                    cnt_d   = CNT_W'(HS_EXIT_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EXIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        hs_d    = (state_d inside {ST_HS_ZERO, ST_SYNC, ST_DATA, ST_TRAIL});
        lpp_d   = {LANES{(state_d == ST_IDLE) || (state_d == ST_EXIT)}};
        lpn_d   = {LANES{state_d inside {ST_IDLE, ST_EXIT, ST_LP01}}};
        stop_d  = (state_d == ST_IDLE);
        // TX_ready is registered, so it looks ahead to the coming phase-3 cycle
        ready_d = ((state_d == ST_SYNC) || (state_d == ST_DATA)) &&
                  (phase_d == 2'd3) && TX_request_HS;

        if ((state_d == ST_SYNC) || (state_d == ST_DATA)) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (load) begin
                    b1_d[i] = new_byte[i][0];
                    b2_d[i] = new_byte[i][1];
                    sr_d[i] = {2'b00, new_byte[i][7:2]};
                end else begin
                    b1_d[i] = sr_q[i][0];
                    b2_d[i] = sr_q[i][1];
                    sr_d[i] = {2'b00, sr_q[i][7:2]};
                end
            end
        end else if (state_d == ST_TRAIL) begin
            // Trail level is fixed on entry as the inverse of the final HS bit
            if (state_q == ST_TRAIL) begin
                b1_d = b1_q;
                b2_d = b2_q;
            end else begin
                b1_d = ~b2_q;
                b2_d = ~b2_q;
            end
        end
    end

    assign TX_ready   = ready_q;
    assign Serial_B1  = b1_q;
    assign Serial_B2  = b2_q;
    assign HS_Enable  = hs_q;
    assign LP_Dp      = lpp_q;
    assign LP_Dn      = lpn_q;
    assign Stop_state = stop_q;
    assign Underrun   = und_q;

endmodule
